// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front-end: issues sequential word fetches to a multi-cycle
// instruction memory (one request outstanding at most), buffers returned words
// with their PCs in a small FIFO, and hands them to the core via valid/ready.
// A redirect flushes the FIFO and restarts fetch at the aligned target.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         mem_req_o,
  output logic [31:0]                  mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic                         instr_valid_o,
  output logic [31:0]                  instr_o,
  output logic [31:0]                  instr_pc_o,
  input  logic                         instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     req_addr_q;
  logic            discard_q;
  logic            mem_req_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_pc_q    [DEPTH];
  logic [31:0]     target;
  logic            push;
  logic            pop;

  assign target = redirect_pc_i & 32'hFFFF_FFFC;
  assign push   = (state_q == S_WAIT) && mem_rvalid_i && !discard_q && !redirect_i;
  assign pop    = instr_valid_o && instr_ready_i && !redirect_i;

  // Occupancy after this cycle's push/pop/flush
  always_comb begin
    count_d = count_q;
    if (redirect_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO pointers and occupancy; redirect flushes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (redirect_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // FIFO storage: instruction word and the PC it was fetched from
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= mem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= req_addr_q;
    end
  end

  // Fetch FSM: request, wait for response, refill while space remains
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_i) begin
            fetch_pc_q <= target;
            req_addr_q <= target;
            mem_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end else if (count_q < FULL) begin
            req_addr_q <= fetch_pc_q;
            mem_req_q  <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // A request cannot be withdrawn, so a redirect here only marks the
          // eventual response for dropping. Once discard is pending,
          // fetch_pc already holds the target and must not be overwritten
          // by the sequential successor at grant time.
          if (redirect_i) begin
            fetch_pc_q <= target;
            discard_q  <= 1'b1;
          end else if (mem_gnt_i && !discard_q) begin
            fetch_pc_q <= req_addr_q + 32'd4;
          end
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            discard_q <= 1'b0;
            if (redirect_i) begin
              fetch_pc_q <= target;
              req_addr_q <= target;
              mem_req_q  <= 1'b1;
              state_q    <= S_REQ;
            end else if (count_d < FULL) begin
              req_addr_q <= fetch_pc_q;
              mem_req_q  <= 1'b1;
              state_q    <= S_REQ;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (redirect_i) begin
            fetch_pc_q <= target;
            discard_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = req_addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : '0;
  assign count_o       = count_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: a memory model answers requests with
// configurable grant/response delays; kept responses go to a scoreboard queue
// and are compared when the core side consumes them. A cycle table covers the
// fill/drain sequence from reset; hand-written sequences cover redirects,
// address wrap and asynchronous reset.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [2:0]  count_o;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  instr_fetch_buffer #(
    .DEPTH   (4),
    .RESET_PC(RST_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    int unsigned cnt;
    logic [31:0] pc;
  } vec_t;
  vec_t tab[18];

  // memory model state
  int unsigned gnt_delay = 0;
  int unsigned rv_delay  = 0;
  int unsigned gnt_cnt   = 0;
  int unsigned rv_cnt    = 0;
  bit          outst     = 1'b0;
  logic [31:0] outst_addr = '0;
  bit          stale     = 1'b0;
  bit          hold_valid = 1'b0;
  logic [31:0] hold_addr = '0;
  // consumer-side model
  logic [31:0] next_exp_pc = RST_PC;
  logic [31:0] last_pop_pc = '0;
  int unsigned pops = 0;

  function automatic logic [31:0] wfn(input logic [31:0] a);
    return (a << 5) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1: checks current outputs, drives this cycle's inputs,
  // then advances to the next sample point.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
    sb_t e;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    instr_ready_i = rdy;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    if (hold_valid) begin
      chk("req_held", 32'(mem_req_o), 32'd1);
      chk("addr_held", mem_addr_o, hold_addr);
    end
    if (redir && (mem_req_o || outst)) stale = 1'b1;
    // response side
    if (outst) begin
      if (rv_cnt >= rv_delay) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = wfn(outst_addr);
        if (!stale && !redir) sb_q.push_back({outst_addr, wfn(outst_addr)});
        outst = 1'b0;
        stale = 1'b0;
      end else begin
        rv_cnt++;
      end
    end
    // request side
    hold_valid = 1'b0;
    if (mem_req_o) begin
      if (gnt_cnt >= gnt_delay) begin
        mem_gnt_i  = 1'b1;
        outst      = 1'b1;
        outst_addr = mem_addr_o;
        rv_cnt     = 0;
        gnt_cnt    = 0;
      end else begin
        gnt_cnt++;
        hold_valid = 1'b1;
        hold_addr  = mem_addr_o;
      end
    end
    // consumer side
    if (instr_valid_o && rdy && !redir) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", instr_pc_o, e.pc);
        chk("sb_instr", instr_o, e.data);
      end
      chk("pc_chain", instr_pc_o, next_exp_pc);
      next_exp_pc = next_exp_pc + 32'd4;
      last_pop_pc = instr_pc_o;
      pops++;
    end
    if (redir) begin
      sb_q.delete();
      next_exp_pc = tgt & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_outst(input logic [31:0] a);
    for (int i = 0; i < 200; i++) begin
      if (outst && outst_addr == a) return;
      step(1'b1, 1'b0, '0);
    end
    chk("wait_outst_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_req_addr(input logic [31:0] a);
    for (int i = 0; i < 200; i++) begin
      if (mem_req_o && !hold_valid && !stale && mem_addr_o == a) return;
      step(1'b1, 1'b0, '0);
    end
    chk("wait_req_timeout", 32'd0, 32'd1);
  endtask

  // next fresh request after a redirect must target the given address
  task automatic expect_next_req(input string name, input logic [31:0] a);
    for (int i = 0; i < 200; i++) begin
      if (mem_req_o && !stale) begin
        chk(name, mem_addr_o, a);
        return;
      end
      step(1'b1, 1'b0, '0);
    end
    chk("next_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pops(input int unsigned n);
    int unsigned target;
    target = pops + n;
    for (int i = 0; i < 400; i++) begin
      if (pops >= target) return;
      step(1'b1, 1'b0, '0);
    end
    chk("pops_timeout", pops, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle-by-cycle fill then drain from reset: {ready, req, addr, count, head pc}
    tab[0]  = '{1'b0, 1'b0, 32'h00, 0, 32'h00};
    tab[1]  = '{1'b0, 1'b1, 32'h00, 0, 32'h00};
    tab[2]  = '{1'b0, 1'b0, 32'h00, 0, 32'h00};
    tab[3]  = '{1'b0, 1'b1, 32'h04, 1, 32'h00};
    tab[4]  = '{1'b0, 1'b0, 32'h04, 1, 32'h00};
    tab[5]  = '{1'b0, 1'b1, 32'h08, 2, 32'h00};
    tab[6]  = '{1'b0, 1'b0, 32'h08, 2, 32'h00};
    tab[7]  = '{1'b0, 1'b1, 32'h0C, 3, 32'h00};
    tab[8]  = '{1'b0, 1'b0, 32'h0C, 3, 32'h00};
    tab[9]  = '{1'b0, 1'b0, 32'h0C, 4, 32'h00};
    tab[10] = '{1'b0, 1'b0, 32'h0C, 4, 32'h00};
    tab[11] = '{1'b1, 1'b0, 32'h0C, 4, 32'h00};
    tab[12] = '{1'b1, 1'b0, 32'h0C, 3, 32'h04};
    tab[13] = '{1'b1, 1'b1, 32'h10, 2, 32'h08};
    tab[14] = '{1'b1, 1'b0, 32'h10, 1, 32'h0C};
    tab[15] = '{1'b1, 1'b1, 32'h14, 1, 32'h10};
    tab[16] = '{1'b1, 1'b0, 32'h14, 0, 32'h00};
    tab[17] = '{1'b1, 1'b1, 32'h18, 1, 32'h14};

    rst_i         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = '0;
    instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, RST_PC);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    rst_i = 1'b1;

    // fill to full with ready low, then drain and resume at 0x10
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("tab%0d_req", i), 32'(mem_req_o), 32'(tab[i].req));
      chk($sformatf("tab%0d_addr", i), mem_addr_o, tab[i].addr);
      chk($sformatf("tab%0d_count", i), 32'(count_o), tab[i].cnt);
      chk($sformatf("tab%0d_valid", i), 32'(instr_valid_o), 32'(tab[i].cnt != 0));
      if (tab[i].cnt != 0) begin
        chk($sformatf("tab%0d_pc", i), instr_pc_o, tab[i].pc);
        chk($sformatf("tab%0d_instr", i), instr_o, wfn(tab[i].pc));
      end
      step(tab[i].rdy, 1'b0, '0);
    end

    // redirect during WAIT for 0x8 (response one cycle later) -> word dropped
    rv_delay = 1;
    step(1'b1, 1'b1, 32'h0);
    wait_outst(32'h8);
    step(1'b1, 1'b1, 32'h100);
    chk("wait_redir_count", 32'(count_o), 32'd0);
    chk("wait_redir_valid", 32'(instr_valid_o), 32'd0);
    expect_next_req("wait_redir_addr", 32'h100);
    run_pops(1);
    chk("wait_redir_first_pc", last_pop_pc, 32'h100);

    // redirect during a REQ whose grant is delayed 3 cycles
    gnt_delay = 3;
    rv_delay  = 0;
    step(1'b1, 1'b1, 32'h0);
    wait_req_addr(32'h8);
    step(1'b1, 1'b1, 32'h200);
    chk("req_redir_addr_kept", mem_addr_o, 32'h8);
    expect_next_req("req_redir_addr", 32'h200);
    run_pops(1);
    chk("req_redir_first_pc", last_pop_pc, 32'h200);

    // unaligned target and address wrap
    gnt_delay = 0;
    step(1'b1, 1'b1, 32'h103);
    expect_next_req("align_addr", 32'h100);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    expect_next_req("wrap_addr", 32'hFFFF_FFFC);
    run_pops(1);
    chk("wrap_pc0", last_pop_pc, 32'hFFFF_FFFC);
    run_pops(1);
    chk("wrap_pc1", last_pop_pc, 32'h0);

    // asynchronous reset in the middle of WAIT with a non-empty FIFO
    rv_delay = 3;
    for (int i = 0; i < 100; i++) begin
      if (outst && count_o != 0) break;
      step(1'b0, 1'b0, '0);
    end
    chk("pre_rst_outst", 32'(outst), 32'd1);
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req_o), 32'd0);
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_addr", mem_addr_o, RST_PC);
    redirect_i    = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    instr_ready_i = 1'b0;
    outst         = 1'b0;
    stale         = 1'b0;
    hold_valid    = 1'b0;
    gnt_cnt       = 0;
    rv_delay      = 0;
    sb_q.delete();
    next_exp_pc   = RST_PC;
    @(posedge clk);
    #1;
    rst_i        = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    chk("late_rvalid_count", 32'(count_o), 32'd0);
    chk("restart_req", 32'(mem_req_o), 32'd1);
    chk("restart_addr", mem_addr_o, RST_PC);
    run_pops(2);
    chk("restart_pc", last_pop_pc, RST_PC + 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
